// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 Hz timing constants, coordinate type and small decode helpers
// for the VGA timing generator.
package vga_timing_pkg;

  localparam int unsigned COORD_W   = 10;
  localparam int unsigned MAX_TOTAL = 1 << COORD_W;

  localparam int unsigned H_DISPLAY_DEF = 640;
  localparam int unsigned H_FRONT_DEF   = 16;
  localparam int unsigned H_SYNC_DEF    = 96;
  localparam int unsigned H_BACK_DEF    = 48;
  localparam int unsigned V_DISPLAY_DEF = 480;
  localparam int unsigned V_FRONT_DEF   = 10;
  localparam int unsigned V_SYNC_DEF    = 2;
  localparam int unsigned V_BACK_DEF    = 33;

  localparam int unsigned CLK_DIV_DEF     = 4;
  localparam logic        SYNC_ACTIVE_DEF = 1'b0;

  localparam int unsigned H_TOTAL_DEF =
    H_DISPLAY_DEF + H_FRONT_DEF + H_SYNC_DEF + H_BACK_DEF;
  localparam int unsigned V_TOTAL_DEF =
    V_DISPLAY_DEF + V_FRONT_DEF + V_SYNC_DEF + V_BACK_DEF;

  localparam int unsigned HS_START_DEF = H_DISPLAY_DEF + H_FRONT_DEF;
  localparam int unsigned HS_END_DEF   = HS_START_DEF + H_SYNC_DEF - 1;
  localparam int unsigned VS_START_DEF = V_DISPLAY_DEF + V_FRONT_DEF;
  localparam int unsigned VS_END_DEF   = VS_START_DEF + V_SYNC_DEF - 1;

  typedef logic [COORD_W-1:0] coord_t;

  function automatic logic in_window(input coord_t c, input coord_t lo, input coord_t hi);
    return (c >= lo) && (c <= hi);
  endfunction

  function automatic logic sync_level(input logic asserted, input logic active);
    return asserted ? active : ~active;
  endfunction

endpackage

// File: rtl/pixel_tick_div.sv
// Free-running clock divider: p_tick is high for one clk in every CLK_DIV.
module pixel_tick_div #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  output logic p_tick
);

  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  generate
    if (CLK_DIV < 1) begin : g_div_check
      $error("pixel_tick_div: CLK_DIV must be >= 1");
    end
  endgenerate

  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] div_d;

  // With CLK_DIV=1 DIV_LAST is 0, so div stays at 0 and p_tick is constantly high.
  always_comb begin
    div_d = div_q + DIV_W'(1);
    if (div_q == DIV_LAST) begin
      div_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_q <= '0;
    end else begin
      div_q <= div_d;
    end
  end

  assign p_tick = (div_q == DIV_LAST);

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel/line counters advanced by the pixel tick, with
// registered syncs, visible-area decode and an end-of-frame pulse.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_DISPLAY   = H_DISPLAY_DEF,
  parameter int unsigned H_FRONT     = H_FRONT_DEF,
  parameter int unsigned H_SYNC      = H_SYNC_DEF,
  parameter int unsigned H_BACK      = H_BACK_DEF,
  parameter int unsigned V_DISPLAY   = V_DISPLAY_DEF,
  parameter int unsigned V_FRONT     = V_FRONT_DEF,
  parameter int unsigned V_SYNC      = V_SYNC_DEF,
  parameter int unsigned V_BACK      = V_BACK_DEF,
  parameter int unsigned CLK_DIV     = CLK_DIV_DEF,
  parameter logic        SYNC_ACTIVE = SYNC_ACTIVE_DEF
) (
  input  logic               clk,
  input  logic               reset,
  output logic               p_tick,
  output logic [COORD_W-1:0] pixel_x,
  output logic [COORD_W-1:0] pixel_y,
  output logic               video_on,
  output logic               hsync,
  output logic               vsync,
  output logic               frame_end
);

  localparam int unsigned H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  generate
    if ((H_TOTAL > MAX_TOTAL) || (V_TOTAL > MAX_TOTAL)) begin : g_total_check
      $error("vga_timing_gen: H_TOTAL and V_TOTAL must not exceed %0d", MAX_TOTAL);
    end
  endgenerate

  localparam coord_t H_LAST   = coord_t'(H_TOTAL - 1);
  localparam coord_t V_LAST   = coord_t'(V_TOTAL - 1);
  localparam coord_t H_VIS    = coord_t'(H_DISPLAY);
  localparam coord_t V_VIS    = coord_t'(V_DISPLAY);
  localparam coord_t HS_FIRST = coord_t'(H_DISPLAY + H_FRONT);
  localparam coord_t HS_LAST  = coord_t'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam coord_t VS_FIRST = coord_t'(V_DISPLAY + V_FRONT);
  localparam coord_t VS_LAST  = coord_t'(V_DISPLAY + V_FRONT + V_SYNC - 1);

  logic   tick;
  coord_t h_q, h_d;
  coord_t v_q, v_d;
  logic   hsync_q, hsync_d;
  logic   vsync_q, vsync_d;

  pixel_tick_div #(
    .CLK_DIV(CLK_DIV)
  ) u_tick_div (
    .clk   (clk),
    .reset (reset),
    .p_tick(tick)
  );

  // Syncs are decoded from the next-state counters so the registered outputs
  // change on the same edge as pixel_x/pixel_y.
  always_comb begin
    h_d = h_q;
    v_d = v_q;
    if (tick) begin
      if (h_q == H_LAST) begin
        h_d = '0;
        v_d = (v_q == V_LAST) ? '0 : v_q + coord_t'(1);
      end else begin
        h_d = h_q + coord_t'(1);
      end
    end
    hsync_d = sync_level(in_window(h_d, HS_FIRST, HS_LAST), SYNC_ACTIVE);
    vsync_d = sync_level(in_window(v_d, VS_FIRST, VS_LAST), SYNC_ACTIVE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      h_q     <= '0;
      v_q     <= '0;
      hsync_q <= ~SYNC_ACTIVE;
      vsync_q <= ~SYNC_ACTIVE;
    end else begin
      h_q     <= h_d;
      v_q     <= v_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
    end
  end

  assign p_tick    = tick;
  assign pixel_x   = h_q;
  assign pixel_y   = v_q;
  assign hsync     = hsync_q;
  assign vsync     = vsync_q;
  assign video_on  = (h_q < H_VIS) && (v_q < V_VIS);
  assign frame_end = tick && (h_q == H_LAST) && (v_q == V_LAST);

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: full 640x480 timing at CLK_DIV=4 plus two reduced
// rasters (CLK_DIV=1 active-low syncs, CLK_DIV=3 active-high syncs).
module tb_vga_timing_gen;

  typedef struct packed {
    logic       p_tick;
    logic [9:0] x;
    logic [9:0] y;
    logic       video_on;
    logic       hsync;
    logic       vsync;
    logic       frame_end;
  } vt_t;

  typedef struct {
    string tag;
    vt_t   exp;
  } sb_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic       a_pt, a_von, a_hs, a_vs, a_fe;
  logic [9:0] a_x, a_y;
  logic       b_pt, b_von, b_hs, b_vs, b_fe;
  logic [9:0] b_x, b_y;
  logic       c_pt, c_von, c_hs, c_vs, c_fe;
  logic [9:0] c_x, c_y;
  vt_t obs_a, obs_b, obs_c;

  assign obs_a = {a_pt, a_x, a_y, a_von, a_hs, a_vs, a_fe};
  assign obs_b = {b_pt, b_x, b_y, b_von, b_hs, b_vs, b_fe};
  assign obs_c = {c_pt, c_x, c_y, c_von, c_hs, c_vs, c_fe};

  vga_timing_gen #(
    .CLK_DIV(4)
  ) dut_a (
    .clk(clk), .reset(reset), .p_tick(a_pt), .pixel_x(a_x), .pixel_y(a_y),
    .video_on(a_von), .hsync(a_hs), .vsync(a_vs), .frame_end(a_fe)
  );

  vga_timing_gen #(
    .H_DISPLAY(20), .H_FRONT(4), .H_SYNC(6), .H_BACK(2),
    .V_DISPLAY(12), .V_FRONT(3), .V_SYNC(2), .V_BACK(4),
    .CLK_DIV(1), .SYNC_ACTIVE(1'b0)
  ) dut_b (
    .clk(clk), .reset(reset), .p_tick(b_pt), .pixel_x(b_x), .pixel_y(b_y),
    .video_on(b_von), .hsync(b_hs), .vsync(b_vs), .frame_end(b_fe)
  );

  vga_timing_gen #(
    .H_DISPLAY(20), .H_FRONT(4), .H_SYNC(6), .H_BACK(2),
    .V_DISPLAY(12), .V_FRONT(3), .V_SYNC(2), .V_BACK(4),
    .CLK_DIV(3), .SYNC_ACTIVE(1'b1)
  ) dut_c (
    .clk(clk), .reset(reset), .p_tick(c_pt), .pixel_x(c_x), .pixel_y(c_y),
    .video_on(c_von), .hsync(c_hs), .vsync(c_vs), .frame_end(c_fe)
  );

  int  checks = 0;
  int  errors = 0;
  sb_t sbq[$];

  // Expected outputs k clk edges after reset release, from the raster geometry.
  function automatic vt_t model(input int unsigned k, input int unsigned d,
                                input int unsigned hd, input int unsigned hf,
                                input int unsigned hs, input int unsigned hb,
                                input int unsigned vd, input int unsigned vf,
                                input int unsigned vs, input int unsigned vb,
                                input logic act);
    vt_t r;
    int unsigned ht = hd + hf + hs + hb;
    int unsigned vt = vd + vf + vs + vb;
    int unsigned n  = k / d;
    int unsigned x  = n % ht;
    int unsigned y  = (n / ht) % vt;
    r.p_tick    = ((k % d) == d - 1);
    r.x         = 10'(x);
    r.y         = 10'(y);
    r.video_on  = (x < hd) && (y < vd);
    r.hsync     = ((x >= hd + hf) && (x < hd + hf + hs)) ? act : ~act;
    r.vsync     = ((y >= vd + vf) && (y < vd + vf + vs)) ? act : ~act;
    r.frame_end = r.p_tick && (x == ht - 1) && (y == vt - 1);
    return r;
  endfunction

  task automatic push3(input int unsigned k);
    sb_t s;
    s.tag = $sformatf("dut_a k=%0d", k);
    s.exp = model(k, 4, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0);
    sbq.push_back(s);
    s.tag = $sformatf("dut_b k=%0d", k);
    s.exp = model(k, 1, 20, 4, 6, 2, 12, 3, 2, 4, 1'b0);
    sbq.push_back(s);
    s.tag = $sformatf("dut_c k=%0d", k);
    s.exp = model(k, 3, 20, 4, 6, 2, 12, 3, 2, 4, 1'b1);
    sbq.push_back(s);
  endtask

  task automatic pop_check(input vt_t obs);
    sb_t s;
    checks++;
    if (sbq.size() == 0) begin
      errors++;
      $error("FAIL sb_empty observed=%h required=entry", obs);
    end else begin
      s = sbq.pop_front();
      assert (obs === s.exp)
      else begin
        errors++;
        $error("FAIL %s observed=%h required=%h", s.tag, obs, s.exp);
      end
    end
  endtask

  task automatic pop3();
    pop_check(obs_a);
    pop_check(obs_b);
    pop_check(obs_c);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h required=%0h", tag, obs, exp);
    end
  endtask

  int hs_cnt   = 0;
  int fe_b0    = -1;
  int fe_b1    = -1;
  int fe_c0    = -1;
  int fe_c1    = -1;
  int first_pt = -1;

  initial begin
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    chk("reset_state_a", 32'(obs_a), 32'({1'b0, 10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0}));
    chk("reset_state_b", 32'(obs_b), 32'({1'b1, 10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0}));
    chk("reset_state_c", 32'(obs_c), 32'({1'b0, 10'd0, 10'd0, 1'b1, 1'b0, 1'b0, 1'b0}));

    // Two full lines of dut_a, several frames of the reduced rasters.
    for (int unsigned k = 0; k < 7602; k++) begin
      push3(k);
      if (k != 0) begin
        @(posedge clk);
        #1;
      end
      pop3();
      if (k < 3200 && obs_a.hsync == 1'b0) hs_cnt++;
      if (obs_b.frame_end) begin
        if (fe_b0 < 0) fe_b0 = int'(k);
        else if (fe_b1 < 0) fe_b1 = int'(k);
      end
      if (obs_c.frame_end) begin
        if (fe_c0 < 0) fe_c0 = int'(k);
        else if (fe_c1 < 0) fe_c1 = int'(k);
      end
    end

    chk("hsync_cycles_line0", 32'(hs_cnt), 32'd384);
    chk("frame_period_b", 32'(fe_b1 - fe_b0), 32'd672);
    chk("frame_period_c", 32'(fe_c1 - fe_c0), 32'd2016);
    chk("pre_reset_x", 32'(obs_a.x), 32'd300);
    chk("pre_reset_y", 32'(obs_a.y), 32'd2);

    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;

    chk("mid_reset_a", 32'(obs_a), 32'({1'b0, 10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0}));
    chk("mid_reset_c", 32'(obs_c), 32'({1'b0, 10'd0, 10'd0, 1'b1, 1'b0, 1'b0, 1'b0}));

    for (int unsigned k = 0; k < 16; k++) begin
      push3(k);
      if (k != 0) begin
        @(posedge clk);
        #1;
      end
      pop3();
      if (obs_a.p_tick && first_pt < 0) first_pt = int'(k);
    end
    chk("first_ptick_after_reset", 32'(first_pt), 32'd3);
    chk("sb_drained", 32'(sbq.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
